// File: rtl/uart_tx_48bytes.sv
// uart_tx_48bytes: serialises a NUM_BYTES-byte parameter frame onto an 8N1 UART
// line. The frame is sent most-significant byte first, each byte LSB first.
// A shadow copy of the frame is taken on acceptance, so the source may change
// freely while the frame is in flight.
module uart_tx_48bytes #(
    parameter int BAUD_DIV  = 434,
    parameter int NUM_BYTES = 48,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_start,
    input  logic [NUM_BYTES*8-1:0] tx_data,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic [5:0]             byte_idx,
    output logic                   Tx
);

    localparam int W    = NUM_BYTES * 8;
    localparam int BW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    // The bit counter is reused for data bits (0..7), stop bits and gap bits.
    localparam int MAXC = (STOP_BITS > 8) ? ((GAP_BITS > STOP_BITS) ? GAP_BITS : STOP_BITS)
                                          : ((GAP_BITS > 8) ? GAP_BITS : 8);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_baud_cnt;
    logic [CW-1:0]   r_bit_cnt;
    logic [W-1:0]    r_shadow;
    logic [5:0]      r_byte_idx;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    logic            w_baud_wrap;
    logic [7:0]      w_top_byte;
    logic [2:0]      w_next_bit;
    logic            w_last_byte;

    // The byte on the line is always the top byte of the shadow register.
    assign w_baud_wrap = (r_baud_cnt == BW'(BAUD_DIV - 1));
    assign w_top_byte  = r_shadow[W-1 -: 8];
    assign w_next_bit  = r_bit_cnt[2:0] + 3'd1;
    assign w_last_byte = (r_byte_idx == 6'(NUM_BYTES - 1));

    // Frame sequencer: bit timing, byte stepping and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shadow   <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Every bit lasts BAUD_DIV cycles; the wrap edge moves to the next bit.
            if (r_state != S_IDLE) begin
                r_baud_cnt <= w_baud_wrap ? '0 : r_baud_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_shadow   <= tx_data;
                        r_byte_idx <= '0;
                        r_busy     <= 1'b1;
                        r_tx       <= 1'b0;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_baud_wrap) begin
                        r_bit_cnt <= '0;
                        r_tx      <= w_top_byte[0];
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_baud_wrap) begin
                        if (r_bit_cnt == CW'(7)) begin
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= w_top_byte[w_next_bit];
                        end
                    end
                end

                S_STOP: begin
                    if (w_baud_wrap) begin
                        if (r_bit_cnt == CW'(STOP_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            if (w_last_byte) begin
                                // Frame complete: back to idle with a one-cycle done pulse.
                                r_byte_idx <= '0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_tx       <= 1'b1;
                                r_state    <= S_IDLE;
                            end else begin
                                r_shadow   <= {r_shadow[W-9:0], 8'h00};
                                r_byte_idx <= r_byte_idx + 6'd1;
                                if (GAP_BITS > 0) begin
                                    r_tx    <= 1'b1;
                                    r_state <= S_GAP;
                                end else begin
                                    r_tx    <= 1'b0;
                                    r_state <= S_START;
                                end
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (w_baud_wrap) begin
                        if (r_bit_cnt == CW'(GAP_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b0;
                            r_state   <= S_START;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Tx       = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;
    assign byte_idx = r_byte_idx;

endmodule

// File: tb/tb_uart_tx_48bytes.sv
// Testbench for uart_tx_48bytes: two instances (48-byte frame with a short baud
// divider, and a 4-byte variant with 2 stop bits and 1 gap bit). The expected
// line level, busy, done and byte index for every cycle are computed from the
// frame layout with plain arithmetic.
module tb_uart_tx_48bytes;

    localparam int A_BAUD = 5;
    localparam int A_NB   = 48;
    localparam int B_BAUD = 8;
    localparam int B_NB   = 4;
    localparam int B_STOP = 2;
    localparam int B_GAP  = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_a = 1'b0;
    logic [383:0] data_a = '0;
    logic         busy_a, done_a, tx_a;
    logic [5:0]   idx_a;
    logic         start_b = 1'b0;
    logic [31:0]  data_b = '0;
    logic         busy_b, done_b, tx_b;
    logic [5:0]   idx_b;

    int checks = 0;
    int errors = 0;
    int prints = 0;

    uart_tx_48bytes #(.BAUD_DIV(A_BAUD), .NUM_BYTES(A_NB), .STOP_BITS(1), .GAP_BITS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_data(data_a),
        .tx_busy(busy_a), .tx_done(done_a), .byte_idx(idx_a), .Tx(tx_a)
    );

    uart_tx_48bytes #(.BAUD_DIV(B_BAUD), .NUM_BYTES(B_NB), .STOP_BITS(B_STOP), .GAP_BITS(B_GAP)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_data(data_b),
        .tx_busy(busy_b), .tx_done(done_b), .byte_idx(idx_b), .Tx(tx_b)
    );

    always #5 clk = ~clk;

    task automatic get_out(input int which, output logic o_tx, output logic o_busy,
                           output logic o_done, output logic [5:0] o_idx);
        if (which == 0) begin
            o_tx = tx_a; o_busy = busy_a; o_done = done_a; o_idx = idx_a;
        end else begin
            o_tx = tx_b; o_busy = busy_b; o_done = done_b; o_idx = idx_b;
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_data(input int which, input logic [383:0] d);
        if (which == 0) data_a = d; else data_b = d[31:0];
    endtask

    task automatic get_params(input int which, output int nb, output int baud,
                              output int stop, output int gap);
        if (which == 0) begin
            nb = A_NB; baud = A_BAUD; stop = 1; gap = 0;
        end else begin
            nb = B_NB; baud = B_BAUD; stop = B_STOP; gap = B_GAP;
        end
    endtask

    // Reference line level t cycles after acceptance: each byte occupies a slot
    // of start + 8 data + stop bits + gap bits, each bit baud cycles long.
    function automatic logic exp_line(input logic [383:0] d, input int nb, input int baud,
                                      input int stop, input int gap, input int t);
        int slot, k, bitn;
        logic [7:0] b;
        slot = (9 + stop + gap) * baud;
        k    = t / slot;
        bitn = (t % slot) / baud;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) begin
            b = d[nb*8-1-8*k -: 8];
            return b[bitn-1];
        end
        return 1'b1;
    endfunction

    // Reference byte index: steps at the end of each byte's stop bits.
    function automatic logic [5:0] exp_idx(input int baud, input int stop, input int gap,
                                           input int t);
        int slot, k, pos;
        slot = (9 + stop + gap) * baud;
        k    = t / slot;
        pos  = t % slot;
        return 6'((pos >= (9 + stop) * baud) ? k + 1 : k);
    endfunction

    function automatic logic [383:0] rand_frame(input int nb);
        logic [383:0] d;
        for (int i = 0; i < 12; i++) d[i*32 +: 32] = $urandom;
        d[nb*8-1 -: 8] = 8'hFA;
        d[7:0]         = 8'hFD;
        return d;
    endfunction

    function automatic logic [383:0] plan_frame();
        logic [383:0] d;
        d = '0;
        d[383:376] = 8'hFA;
        d[375:368] = 8'hFB;
        for (int i = 0; i < 44; i++) d[367-8*i -: 8] = 8'(i);
        d[15:8] = 8'hFC;
        d[7:0]  = 8'hFD;
        return d;
    endfunction

    // Called just after a clock edge with the DUT idle; returns just after the
    // accepting edge (t = 0 of the frame).
    task automatic start_frame(input int which, input logic [383:0] d, input bit hold);
        set_data(which, d);
        set_start(which, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(which, 1'b0);
    endtask

    // Cycle-by-cycle comparison of one frame against the reference, from t = 0
    // to the tx_done cycle. Optional stray request at poke_t and data change
    // at change_t (both ignored by a correct DUT). Without chain, one more idle
    // cycle is checked for a clean return to IDLE.
    task automatic check_frame(input int which, input logic [383:0] d, input string tag,
                               input int poke_t, input logic [383:0] poke_d,
                               input int change_t, input logic [383:0] change_d,
                               input bit chain);
        int nb, baud, stop, gap, len;
        logic o_tx, o_busy, o_done, e_tx;
        logic [5:0] o_idx, e_idx;
        get_params(which, nb, baud, stop, gap);
        len = nb * (9 + stop + gap) * baud - gap * baud;
        for (int t = 0; t <= len; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            get_out(which, o_tx, o_busy, o_done, o_idx);
            if (t < len) begin
                e_tx  = exp_line(d, nb, baud, stop, gap, t);
                e_idx = exp_idx(baud, stop, gap, t);
            end else begin
                e_tx  = 1'b1;
                e_idx = 6'd0;
            end
            checks++;
            if (o_tx !== e_tx) begin
                errors++;
                if (prints < 20) $display("FAIL %s line t=%0d got %b expected %b", tag, t, o_tx, e_tx);
                prints++;
            end
            checks++;
            if (o_busy !== (t < len)) begin
                errors++;
                if (prints < 20) $display("FAIL %s busy t=%0d got %b expected %b", tag, t, o_busy, (t < len));
                prints++;
            end
            checks++;
            if (o_done !== (t == len)) begin
                errors++;
                if (prints < 20) $display("FAIL %s done t=%0d got %b expected %b", tag, t, o_done, (t == len));
                prints++;
            end
            checks++;
            if (o_idx !== e_idx) begin
                errors++;
                if (prints < 20) $display("FAIL %s byte_idx t=%0d got %0d expected %0d", tag, t, o_idx, e_idx);
                prints++;
            end
            if (t == poke_t) begin
                set_data(which, poke_d);
                set_start(which, 1'b1);
            end
            if (t == poke_t + 1) set_start(which, 1'b0);
            if (t == change_t) set_data(which, change_d);
        end
        if (!chain) begin
            @(posedge clk); #1;
            get_out(which, o_tx, o_busy, o_done, o_idx);
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_tx !== 1'b1) begin
                errors++;
                $display("FAIL %s after_frame done=%b busy=%b tx=%b expected done=0 busy=0 tx=1",
                         tag, o_done, o_busy, o_tx);
            end
        end
        $display("frame %s dut=%0d len=%0d checks=%0d errors=%0d", tag, which, len, checks, errors);
    endtask

    task automatic test_reset();
        logic o_tx, o_busy, o_done;
        logic [5:0] o_idx;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            get_out(w, o_tx, o_busy, o_done, o_idx);
            checks++;
            if (o_tx !== 1'b1) begin errors++; $display("FAIL reset tx dut=%0d got %b expected 1", w, o_tx); end
            checks++;
            if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy dut=%0d got %b expected 0", w, o_busy); end
            checks++;
            if (o_done !== 1'b0) begin errors++; $display("FAIL reset done dut=%0d got %b expected 0", w, o_done); end
            checks++;
            if (o_idx !== 6'd0) begin errors++; $display("FAIL reset byte_idx dut=%0d got %0d expected 0", w, o_idx); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single_frame();
        start_frame(0, plan_frame(), 1'b0);
        check_frame(0, plan_frame(), "plan_frame", -5, '0, -5, '0, 1'b0);
    endtask

    task automatic test_random_frames();
        logic [383:0] d;
        for (int i = 0; i < 3; i++) begin
            d = rand_frame(A_NB);
            start_frame(0, d, 1'b0);
            check_frame(0, d, $sformatf("random_%0d", i), -5, '0, -5, '0, 1'b0);
        end
    endtask

    task automatic test_busy_ignore();
        logic [383:0] d;
        d = rand_frame(A_NB);
        start_frame(0, d, 1'b0);
        check_frame(0, d, "busy_ignore", 100, rand_frame(A_NB), 300, rand_frame(A_NB), 1'b0);
        set_start(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [383:0] d1, d2;
        d1 = rand_frame(A_NB);
        d2 = rand_frame(A_NB);
        start_frame(0, d1, 1'b1);
        check_frame(0, d1, "b2b_first", -5, '0, 10, d2, 1'b1);
        // tx_start still high: the very next edge must accept frame two.
        @(posedge clk); #1;
        set_start(0, 1'b0);
        check_frame(0, d2, "b2b_second", -5, '0, -5, '0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [383:0] d;
        int target;
        d = plan_frame();
        // Byte 20, data bit 3: slot 50 cycles, bit 3 spans cycles 20..24 of the slot.
        target = 20 * 10 * A_BAUD + 4 * A_BAUD + 1;
        start_frame(0, d, 1'b0);
        repeat (target) @(posedge clk);
        #1;
        checks++;
        if (tx_a !== exp_line(d, A_NB, A_BAUD, 1, 0, target)) begin
            errors++;
            $display("FAIL rst_mid pre_line got %b expected %b", tx_a, exp_line(d, A_NB, A_BAUD, 1, 0, target));
        end
        checks++;
        if (idx_a !== 6'd20) begin errors++; $display("FAIL rst_mid pre_idx got %0d expected 20", idx_a); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_mid tx got %b expected 1", tx_a); end
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %b expected 0", busy_a); end
        checks++;
        if (idx_a !== 6'd0) begin errors++; $display("FAIL rst_mid byte_idx got %0d expected 0", idx_a); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done_a !== 1'b0 || tx_a !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid hold done=%b tx=%b expected done=0 tx=1", done_a, tx_a);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid release done=%b busy=%b expected 0 0", done_a, busy_a);
        end
        d = rand_frame(A_NB);
        start_frame(0, d, 1'b0);
        check_frame(0, d, "after_reset", -5, '0, -5, '0, 1'b0);
    endtask

    task automatic test_variant();
        logic [383:0] d;
        for (int i = 0; i < 3; i++) begin
            d = rand_frame(B_NB);
            start_frame(1, d, 1'b0);
            check_frame(1, d, $sformatf("variant_%0d", i), (i == 1) ? 40 : -5, rand_frame(B_NB),
                        (i == 2) ? 90 : -5, rand_frame(B_NB), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_variant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_48bytes.md
Name: uart_tx_48bytes

Overview:
- Serialises a 48-byte (384-bit) parameter frame onto a UART line, 8N1, LSB-first within each byte.
- Transmit-side counterpart of the 48-byte frame receiver: a frame sent by this block, looped back, reassembles in the receiver with byte [383:376] at the top and [7:0] at the bottom.
- Sits between the parameter register bank / frame builder and the Tx pin.
- Frame format: header 0xFA in the first byte, trailer 0xFD in the last byte; the frame is supplied by the user.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); counter runs 0..BAUD_DIV-1.
- NUM_BYTES, 48, bytes per frame; data width is NUM_BYTES*8.
- STOP_BITS, 1, stop bits per byte (1 or 2).
- GAP_BITS, 0, extra idle-high bit times inserted between bytes (not after the last byte).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_start  input  1  frame request; sampled only in IDLE.
- tx_data  input  NUM_BYTES*8  frame; bits [NUM_BYTES*8-1 -: 8] are sent first, [7:0] last.
- tx_busy  output  1  high from acceptance until the frame completes.
- tx_done  output  1  one-cycle pulse when the last stop bit (and any gap) has ended.
- byte_idx  output  6  index of the byte currently on the line, 0..NUM_BYTES-1.
- Tx  output  1  serial line; idles high; registered.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: Tx=1, tx_busy=0, tx_done=0, byte_idx=0, state=IDLE, baud counter=0, shadow register=0.
- Reset mid-frame: Tx returns high asynchronously and the frame is abandoned. No tx_done is issued.
- States: IDLE, START, DATA, STOP, GAP.
- IDLE:
  - On the edge where tx_start=1: load the shadow register with tx_data, set byte_idx=0, tx_busy=1, Tx=0, baud counter=0, go to START.
  - Tx is low in the cycle after the sampling edge (zero-cycle request latency).
- Bit timing: every bit (start, data, stop, gap) holds for exactly BAUD_DIV cycles. The baud counter wraps at BAUD_DIV-1, and that wrap edge advances to the next bit.
- START: after BAUD_DIV cycles, go to DATA with bit index 0 and Tx = shadow top byte bit 0.
- DATA: 8 bits, LSB first. After bit 7 ends, go to STOP with Tx=1.
- STOP:
  - Lasts STOP_BITS*BAUD_DIV cycles.
  - If this is not the last byte: shift the shadow register left 8 and increment byte_idx. Then go to GAP if GAP_BITS>0, otherwise go straight to START (Tx=0).
  - If this is the last byte: go to IDLE, tx_busy=0, pulse tx_done for that one edge.
- GAP: Tx=1 for GAP_BITS*BAUD_DIV cycles, then START.
- Frame length: NUM_BYTES*(10+STOP_BITS-1+GAP_BITS)*BAUD_DIV - GAP_BITS*BAUD_DIV cycles. Default is 48*10*434 = 208320 cycles.
- Requests and inputs while busy:
  - tx_start while tx_busy=1 is ignored; there is no queueing.
  - tx_data changes after acceptance do not affect the frame in flight.
- Back-to-back: tx_start held high across the tx_done edge is accepted on the next cycle (IDLE). The minimum inter-frame idle is 1 cycle.
- byte_idx changes only on the byte-boundary edge; it reads NUM_BYTES-1 during the final byte and 0 in IDLE.

Test Plan:
- Single frame: tx_data = {8'hFA, 8'hFB, 44 bytes of 0x00..0x2B, 8'hFC, 8'hFD}, pulse tx_start.
  - Bench UART model decodes 48 bytes in order FA, FB, 00..2B, FC, FD.
  - tx_done occurs exactly 208320 cycles after acceptance.
  - tx_busy is high for exactly that window.
- Bit timing: measure the first start bit = 434 cycles low; bit 0 of 0xFA = 0, bit 1 = 1; stop bit high for 434 cycles; no glitch at byte boundaries.
- Loopback: connect Tx to the 48-byte receiver (en_rec=1).
  - Receiver Uart_Data equals tx_data after the frame.
  - A frame with header 0xFE leaves Uart_Data unchanged.
- Busy ignore: second tx_start at cycle 1000 with different tx_data, then tx_data changed at cycle 5000 → line output is still the first frame; exactly one tx_done.
- Reset mid-frame: assert rst_n=0 during byte 20, bit 3 → Tx=1 immediately, tx_busy=0, byte_idx=0, no tx_done. A new tx_start after release sends a complete correct frame.
- Parameter variant: BAUD_DIV=8, STOP_BITS=2, GAP_BITS=1, NUM_BYTES=4 → frame length = 4*12*8 - 8 = 376 cycles; gaps observed only between bytes.
